// File: rtl/psram_pkg.sv
// Shared types and default geometry for the Gowin PSRAM HS command-port arbiter.
package psram_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam int PSRAM_ADDR_WIDTH = 21;
  localparam int PSRAM_DATA_WIDTH = 128;
  localparam int PSRAM_MASK_WIDTH = 16;
  localparam int PSRAM_BEATS      = 4;
  localparam int PSRAM_CMD_GAP    = 18;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/psram_arbiter_if.sv
// Command/data port of the PSRAM HS controller, seen from the arbiter (master) and controller (slave).
interface psram_arbiter_if
  import psram_pkg::*;
#(
  parameter int ADDR_WIDTH = PSRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = PSRAM_DATA_WIDTH,
  parameter int MASK_WIDTH = PSRAM_MASK_WIDTH
);
  // cmd_en is a one-cycle strobe qualifying cmd/addr; there is no ready, so the master
  // owns command spacing. Write beats follow back to back from the cmd_en cycle, and
  // rd_data_valid qualifies rd_data_in only in the cycle it is high.
  logic                  cmd;
  logic                  cmd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] data_mask;
  logic [DATA_WIDTH-1:0] rd_data_in;
  logic                  rd_data_valid;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data_in, rd_data_valid
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data_in, rd_data_valid
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr wins (one-hot + index).
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);
  int            sum;
  logic [PW-1:0] idx;

  // Walk from the farthest candidate back to ptr so the closest requester is written last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    sum     = 0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM HS controller command port among NUM_REQ requesters.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = PSRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = PSRAM_DATA_WIDTH,
  parameter int MASK_WIDTH = PSRAM_MASK_WIDTH,
  parameter int BEATS      = PSRAM_BEATS,
  parameter int CMD_GAP    = PSRAM_CMD_GAP,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             init_calib,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_wmask,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               wr_next,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [1:0]                       rd_beat,
  output logic                             busy,
  output logic                             error,
  output state_t                           dbg_state,
  psram_arbiter_if.master                  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_t                state, state_nxt;
  logic [PW-1:0]         ptr, owner, win_idx;
  logic [NUM_REQ-1:0]    win, owner_oh;
  logic                  win_any, issue, rd_last, rd_expired;
  logic [GW-1:0]         gap;
  logic [BW-1:0]         wbeat, rbeat;
  logic [TW-1:0]         tcnt;
  logic                  cmd_q, cmd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  assign owner_oh   = NUM_REQ'(1) << owner;
  assign issue      = (state == IDLE) && init_calib && win_any && (gap == '0);
  assign rd_last    = bus.rd_data_valid && (rbeat == BW'(BEATS - 1));
  assign rd_expired = (tcnt == TW'(RD_TIMEOUT - 1));

  // busy means a burst is in flight, so INIT (the reset state) reads as not busy.
  assign busy       = (state == WRITE) || (state == READ);
  assign dbg_state  = state;
  assign bus.cmd    = cmd_q;
  assign bus.cmd_en = cmd_en_q;
  assign bus.addr   = addr_q;

  always_comb begin
    state_nxt     = state;
    wr_next       = '0;
    bus.wr_data   = '0;
    bus.data_mask = '0;
    case (state)
      INIT:  if (init_calib) state_nxt = IDLE;
      IDLE:  if (issue) state_nxt = req_we[win_idx] ? WRITE : READ;
      WRITE: begin
        wr_next       = owner_oh;
        bus.wr_data   = req_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
        bus.data_mask = req_wmask[owner*MASK_WIDTH +: MASK_WIDTH];
        if (wbeat == BW'(BEATS - 1)) state_nxt = IDLE;
      end
      READ:  if (rd_last || rd_expired) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
    // Losing calibration abandons any burst on the spot.
    if (!init_calib) begin
      state_nxt = INIT;
      wr_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      ptr      <= '0;
      owner    <= '0;
      gap      <= '0;
      wbeat    <= '0;
      rbeat    <= '0;
      tcnt     <= '0;
      grant    <= '0;
      cmd_q    <= 1'b0;
      cmd_en_q <= 1'b0;
      addr_q   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      rd_beat  <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= '0;
      cmd_en_q <= 1'b0;
      rd_valid <= '0;
      if (gap != '0) gap <= gap - 1'b1;
      if (issue) begin
        grant    <= win;
        cmd_en_q <= 1'b1;
        cmd_q    <= req_we[win_idx] ? CMD_WRITE : CMD_READ;
        addr_q   <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        owner    <= win_idx;
        ptr      <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        gap      <= GW'(CMD_GAP - 1);
        wbeat    <= '0;
        rbeat    <= '0;
        tcnt     <= '0;
      end
      if (state == WRITE) wbeat <= wbeat + 1'b1;
      if (state == READ && init_calib) begin
        tcnt <= tcnt + 1'b1;
        if (bus.rd_data_valid) begin
          rd_valid <= owner_oh;
          rd_data  <= bus.rd_data_in;
          rd_beat  <= 2'(rbeat);
          rbeat    <= rbeat + 1'b1;
        end
        if (rd_expired && !rd_last) error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter with a requester model, a controller model and a read scoreboard.
module tb_psram_arbiter;
  import psram_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int AW = 21;
  localparam int DW = 128;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_calib = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] req_we = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ*MW-1:0] req_wmask = '0;
  logic [NUM_REQ-1:0] grant, wr_next, rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0] rd_beat;
  logic busy, error;
  state_t dbg_state;

  psram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  psram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .BEATS(4), .CMD_GAP(18), .RD_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib(init_calib),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .grant(grant), .wr_next(wr_next), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_beat(rd_beat), .busy(busy), .error(error),
    .dbg_state(dbg_state), .bus(bus)
  );

  // clock/reset
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passes = 0;
  bit ctl_respond = 1'b0;
  int exp_rd_owner = 0;
  int mon_beat = 0;
  int model_ptr = 0;
  int rv_cnt0 = 0;
  int rv_cnt1 = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wexp_q[$];
  logic [DW-1:0] wbase[NUM_REQ];
  int wbeat[NUM_REQ];

  // Requester model: beat k of a burst is wbase + k; advances after each wr_next.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_wdata[i*DW +: DW] = wbase[i] + DW'(wbeat[i]);
  end

  always begin
    logic [NUM_REQ-1:0] nxt;
    @(negedge clk);
    nxt = wr_next;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (nxt[i]) wbeat[i]++;
  end

  // Controller model: four read beats starting 12 cycles after a read cmd_en.
  always begin
    logic [DW-1:0] d;
    @(negedge clk);
    if (bus.cmd_en === 1'b1 && bus.cmd === 1'b0 && ctl_respond) begin
      repeat (11) @(posedge clk);
      for (int b = 0; b < 4; b++) begin
        @(posedge clk);
        #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.rd_data_in = d;
        bus.rd_data_valid = 1'b1;
        exp_q.push_back(d);
      end
      @(posedge clk);
      #1;
      bus.rd_data_valid = 1'b0;
    end
  end

  // Read scoreboard
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rd_valid !== '0) begin
      rv_cnt0 += int'(rd_valid[0]);
      rv_cnt1 += int'(rd_valid[1]);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected rd_valid=%b with no beat expected", rd_valid);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e || rd_valid !== 2'(1 << exp_rd_owner) || rd_beat !== 2'(mon_beat))
          $display("FAIL rd_beat got valid=%b beat=%0d data=%h want valid=%b beat=%0d data=%h",
                   rd_valid, rd_beat, rd_data, 2'(1 << exp_rd_owner), mon_beat, e);
        else passes++;
      end
      mon_beat = (mon_beat + 1) % 4;
    end
  end

  task automatic wait_cmd(input int limit, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (bus.cmd_en === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cmd_en, bus.cmd, grant, wr_next, rd_valid, busy, error, rd_beat} !== '0)
      $display("FAIL reset_ctrl got %b want 0",
               {bus.cmd_en, bus.cmd, grant, wr_next, rd_valid, busy, error, rd_beat});
    else passes++;
    checks++;
    if ({bus.addr, bus.wr_data, bus.data_mask, rd_data} !== '0)
      $display("FAIL reset_data got addr=%h wr=%h mask=%h rd=%h want 0",
               bus.addr, bus.wr_data, bus.data_mask, rd_data);
    else passes++;
    checks++;
    if (dbg_state !== INIT) $display("FAIL reset_state got %0d want %0d", dbg_state, INIT);
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_init_gate;
    int n_cmd;
    bit seen;
    n_cmd = 0;
    req_addr[0 +: AW] = 21'h12345;
    req_we[0] = 1'b0;
    req[0] = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.cmd_en === 1'b1) n_cmd++;
    end
    checks++;
    if (n_cmd != 0) $display("FAIL init_gate got %0d cmd_en want 0", n_cmd);
    else passes++;
    ctl_respond = 1'b1;
    @(posedge clk);
    #1 init_calib = 1'b1;
    wait_cmd(10, seen);
    req[0] = 1'b0;
    checks++;
    if (!seen) $display("FAIL init_grant_timeout got no cmd_en want cmd_en within 10 cycles");
    else passes++;
    checks++;
    if (grant !== 2'b01 || bus.addr !== 21'h12345 || bus.cmd !== CMD_READ)
      $display("FAIL init_grant got grant=%b addr=%h cmd=%b want 01 12345 0", grant, bus.addr, bus.cmd);
    else passes++;
    exp_rd_owner = 0;
    model_ptr = 1;
    repeat (24) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL init_read_drain got %0d beats left want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_write;
    bit seen;
    logic [DW-1:0] e;
    repeat (20) @(negedge clk);
    wbase[1] = DW'('hA0);
    wbeat[1] = 0;
    req_wmask[MW +: MW] = 16'h0F0F;
    req_addr[AW +: AW] = 21'h1ABCD;
    req_we[1] = 1'b1;
    for (int k = 0; k < 4; k++) wexp_q.push_back(DW'('hA0 + k));
    req[1] = 1'b1;
    wait_cmd(30, seen);
    req[1] = 1'b0;
    checks++;
    if (!seen || grant !== 2'b10 || bus.cmd !== CMD_WRITE || bus.addr !== 21'h1ABCD)
      $display("FAIL write_cmd got seen=%0d grant=%b cmd=%b addr=%h want 1 10 1 1abcd",
               seen, grant, bus.cmd, bus.addr);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      e = wexp_q.pop_front();
      checks++;
      if (wr_next !== 2'b10 || bus.wr_data !== e || bus.data_mask !== 16'h0F0F)
        $display("FAIL write_beat%0d got next=%b data=%h mask=%h want 10 %h 0f0f",
                 k, wr_next, bus.wr_data, bus.data_mask, e);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (wr_next !== 2'b00 || busy !== 1'b0)
      $display("FAIL write_end got next=%b busy=%b want 00 0", wr_next, busy);
    else passes++;
    model_ptr = 0;
  endtask

  task automatic test_alternate;
    bit seen;
    longint last;
    int exp_idx;
    last = 0;
    repeat (20) @(negedge clk);
    req_we = 2'b00;
    req_addr = {21'h0B0B0, 21'h0A0A0};
    ctl_respond = 1'b1;
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_idx = model_ptr;
      wait_cmd(40, seen);
      checks++;
      if (!seen || grant !== 2'(1 << exp_idx))
        $display("FAIL alt_grant%0d got seen=%0d grant=%b want %b", g, seen, grant, 2'(1 << exp_idx));
      else passes++;
      if (g > 0) begin
        checks++;
        if (cyc - last < 18) $display("FAIL alt_gap%0d got %0d cycles want >= 18", g, cyc - last);
        else passes++;
      end
      last = cyc;
      exp_rd_owner = exp_idx;
      model_ptr = (exp_idx + 1) % NUM_REQ;
    end
    req = 2'b00;
    repeat (24) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL alt_drain got %0d beats left want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_read_routing;
    bit seen;
    int c0, c1;
    repeat (20) @(negedge clk);
    c0 = rv_cnt0;
    c1 = rv_cnt1;
    ctl_respond = 1'b1;
    req_we[0] = 1'b0;
    req[0] = 1'b1;
    wait_cmd(30, seen);
    req[0] = 1'b0;
    exp_rd_owner = 0;
    checks++;
    if (!seen || grant !== 2'b01) $display("FAIL route_grant got seen=%0d grant=%b want 01", seen, grant);
    else passes++;
    repeat (24) @(negedge clk);
    checks++;
    if (rv_cnt0 - c0 != 4 || rv_cnt1 - c1 != 0)
      $display("FAIL route_count got r0=%0d r1=%0d want 4 0", rv_cnt0 - c0, rv_cnt1 - c1);
    else passes++;
    model_ptr = 1;
  endtask

  task automatic test_timeout;
    bit seen;
    ctl_respond = 1'b0;
    req_we[1] = 1'b0;
    req[1] = 1'b1;
    wait_cmd(30, seen);
    req[1] = 1'b0;
    checks++;
    if (!seen || grant !== 2'b10) $display("FAIL tmo_grant got seen=%0d grant=%b want 10", seen, grant);
    else passes++;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        checks++;
        if (error !== 1'b0 || busy !== 1'b1)
          $display("FAIL tmo_early got error=%b busy=%b want 0 1", error, busy);
        else passes++;
      end
      if (k == 64) begin
        checks++;
        if (error !== 1'b1 || busy !== 1'b0)
          $display("FAIL tmo_fire got error=%b busy=%b want 1 0", error, busy);
        else passes++;
      end
    end
    ctl_respond = 1'b1;
    req_we[0] = 1'b0;
    req[0] = 1'b1;
    wait_cmd(10, seen);
    req[0] = 1'b0;
    exp_rd_owner = 0;
    checks++;
    if (!seen || grant !== 2'b01 || error !== 1'b1)
      $display("FAIL tmo_next got seen=%0d grant=%b error=%b want 1 01 1", seen, grant, error);
    else passes++;
    repeat (24) @(negedge clk);
    checks++;
    if (error !== 1'b1 || exp_q.size() != 0)
      $display("FAIL tmo_sticky got error=%b left=%0d want 1 0", error, exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid_write;
    bit seen;
    int n_ev;
    repeat (20) @(negedge clk);
    wbase[0] = DW'('hB0);
    wbeat[0] = 0;
    req_wmask[0 +: MW] = 16'h00FF;
    req_we[0] = 1'b1;
    req[0] = 1'b1;
    wait_cmd(30, seen);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!seen || wr_next !== 2'b01 || bus.wr_data !== DW'('hB2))
      $display("FAIL rst_pre got seen=%0d next=%b data=%h want 1 01 b2", seen, wr_next, bus.wr_data);
    else passes++;
    rst_n = 1'b0;
    init_calib = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_en, bus.cmd, grant, wr_next, rd_valid, busy, error, rd_beat} !== '0 ||
        {bus.addr, bus.wr_data, bus.data_mask, rd_data} !== '0 || dbg_state !== INIT)
      $display("FAIL rst_mid got ctrl=%b addr=%h wr=%h state=%0d want all 0 INIT",
               {bus.cmd_en, bus.cmd, grant, wr_next, rd_valid, busy, error, rd_beat},
               bus.addr, bus.wr_data, dbg_state);
    else passes++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wbeat[0] = 0;
    req[0] = 1'b1;
    n_ev = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_next !== 2'b00 || bus.cmd_en !== 1'b0) n_ev++;
    end
    checks++;
    if (n_ev != 0) $display("FAIL rst_quiet got %0d active cycles want 0", n_ev);
    else passes++;
    @(posedge clk);
    #1 init_calib = 1'b1;
    wait_cmd(10, seen);
    req[0] = 1'b0;
    checks++;
    if (!seen || grant !== 2'b01) $display("FAIL rst_regrant got seen=%0d grant=%b want 01", seen, grant);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (wr_next !== 2'b01 || bus.wr_data !== DW'('hB0 + k) || bus.data_mask !== 16'h00FF)
        $display("FAIL rst_beat%0d got next=%b data=%h mask=%h want 01 %h 00ff",
                 k, wr_next, bus.wr_data, bus.data_mask, DW'('hB0 + k));
      else passes++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.rd_data_valid = 1'b0;
    bus.rd_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wbase[i] = '0;
      wbeat[i] = 0;
    end
    test_reset;
    test_init_gate;
    test_write;
    test_alternate;
    test_read_routing;
    test_timeout;
    test_reset_mid_write;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200000 want finish");
    $fatal(1, "watchdog");
  end
endmodule
